alu_mul_seq: RTL
================

Name: alu_mul_seq

Overview:
- Multi-cycle unsigned multiplier controller that sequences the shared 64-bit LEGv8 ALU with a shift-add algorithm.
- It borrows the ALU's ADD and PASS-B operations and its zero flag instead of instantiating its own adder.
- It sits beside the datapath ALU. A MUL-capable execute stage (or a test harness) issues start/operands and waits for done.
- Result is the low N bits of the product, plus an overflow flag and an iteration count.

Parameters:
- N, 64, operand/result width; must match the ALU width.
- CW, $clog2(N+1), width of the iteration counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- op_a  in  N  multiplicand; sampled on accept.
- op_b  in  N  multiplier; sampled on accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, high exactly in DONE.
- product  out  N  registered result; holds until the next DONE.
- ovf  out  1  registered; true 2N-bit product did not fit in N bits.
- iter  out  CW  registered count of SHIFT cycles in the last operation.
- alu_a  out  N  ALU operand A.
- alu_b  out  N  ALU operand B.
- alu_ctrl  out  4  ALU control: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 PASS B.
- alu_result  in  N  combinational ALU result.
- alu_zero  in  1  ALU zero flag (alu_result == 0).

Behaviour:
- Internal registers:
  - M (multiplicand), Q (multiplier), P (accumulator), all N bits.
  - cnt, CW bits.
  - sovf, sticky overflow bit.
- Reset (reset==0 at a posedge):
  - state=IDLE.
  - product=0, ovf=0, iter=0, done=0, busy=0.
  - M=Q=P=0, cnt=0, sovf=0.
  - Reset applies mid-operation too; the operation is abandoned with no done.
- IDLE:
  - Outputs alu_ctrl=0, alu_a=0, alu_b=0.
  - If start=1 at a posedge: M<=op_a, Q<=op_b, P<=0, cnt<=0, sovf<=0; go to CHECK.
- CHECK:
  - Outputs alu_ctrl=7, alu_a=0, alu_b=Q.
  - If alu_zero, go to DONE.
  - Else if Q[0], go to ADD.
  - Else go to SHIFT.
- ADD:
  - Outputs alu_ctrl=2, alu_a=P, alu_b=M.
  - P<=alu_result.
  - If alu_result < P (unsigned carry-out), sovf<=1.
  - Go to SHIFT.
- SHIFT:
  - Outputs alu_ctrl=7, alu_a=0, alu_b=Q.
  - If M[N-1]==1 and (Q>>1)!=0, sovf<=1.
  - M<=M<<1, Q<=Q>>1, cnt<=cnt+1.
  - Go to CHECK.
- DONE:
  - done=1, busy=1, alu_ctrl=0, alu_a=0, alu_b=0.
  - Entry into DONE (the posedge leaving CHECK) loads product<=P, ovf<=sovf (including a carry flagged in the final ADD), iter<=cnt.
  - Unconditionally go to IDLE next cycle.
- Termination:
  - Q reaches 0 after at most N shifts, so cnt never exceeds N.
  - No separate iteration limit is needed; cnt is informational.
- Busy cycles per operation: 2 + 2*s + a.
  - s = number of SHIFTs = index of the highest set bit of op_b plus 1 (0 if op_b=0).
  - a = popcount(op_b).
- start while busy (including DONE) is ignored; no queueing.
- start in the same cycle IDLE is re-entered from DONE is not accepted; the earliest accept is the following cycle.
- product, ovf and iter are unchanged from DONE until the next DONE or reset.

Test Plan:
1. op_a=3, op_b=5, start pulse -> busy for exactly 10 cycles; done 1-cycle pulse in the 10th; product=0xF, ovf=0, iter=3.
2. op_a=0xFFFFFFFFFFFFFFFF, op_b=0 -> busy 2 cycles (CHECK, DONE); product=0, ovf=0, iter=0; alu_ctrl=7 with alu_b=0 during CHECK.
3. op_a=0xF000000000000000, op_b=2 -> product=0xE000000000000000, ovf=1 (flagged on the first SHIFT), iter=2.
4. op_a=op_b=0xFFFFFFFFFFFFFFFF -> product=0x0000000000000001, ovf=1, iter=64, busy 194 cycles.
5. Accept op_a=7, op_b=6; drive start=1 with op_a=2, op_b=2 while busy -> single done; product=0x2A; second request ignored.
6. op_a=3, op_b=5, reset=0 for one cycle during ADD -> next cycle busy=0, done=0, product=0, alu_ctrl=0; no done pulse. A fresh start with 4×4 -> product=0x10.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier that drives the shared LEGv8 ALU.
// It uses the ALU's ADD to accumulate partial products. It uses PASS-B plus the
// ALU zero flag to test whether the multiplier has run out of set bits.
module alu_mul_seq #(
    parameter int N  = 64,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  op_a,
    input  logic [N-1:0]  op_b,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  product,
    output logic          ovf,
    output logic [CW-1:0] iter,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [3:0]    alu_ctrl,
    input  logic [N-1:0]  alu_result,
    input  logic          alu_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_PASS = 4'd7;

    state_t         state, state_nxt;
    logic [N-1:0]   m_r, q_r, p_r;
    logic [CW-1:0]  cnt;
    logic           sovf;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and ALU operand steering
    always_comb begin
        state_nxt = state;
        alu_ctrl  = ALU_AND;
        alu_a     = '0;
        alu_b     = '0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                alu_ctrl = ALU_PASS;
                alu_b    = q_r;
                if (alu_zero)    state_nxt = S_DONE;
                else if (q_r[0]) state_nxt = S_ADD;
                else             state_nxt = S_SHIFT;
            end
            S_ADD: begin
                alu_ctrl  = ALU_ADD;
                alu_a     = p_r;
                alu_b     = m_r;
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                alu_ctrl  = ALU_PASS;
                alu_b     = q_r;
                state_nxt = S_CHECK;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status flags derived directly from the state
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Working registers and the result registers that are loaded on entry to DONE
    always_ff @(posedge clk) begin
        if (!reset) begin
            m_r     <= '0;
            q_r     <= '0;
            p_r     <= '0;
            cnt     <= '0;
            sovf    <= 1'b0;
            product <= '0;
            ovf     <= 1'b0;
            iter    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        m_r  <= op_a;
                        q_r  <= op_b;
                        p_r  <= '0;
                        cnt  <= '0;
                        sovf <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (alu_zero) begin
                        product <= p_r;
                        ovf     <= sovf;
                        iter    <= cnt;
                    end
                end
                S_ADD: begin
                    p_r <= alu_result;
                    if (alu_result < p_r) sovf <= 1'b1;
                end
                S_SHIFT: begin
                    // A multiplicand bit leaving the top matters only if multiplier bits remain
                    if (m_r[N-1] && ((q_r >> 1) != '0)) sovf <= 1'b1;
                    m_r <= m_r << 1;
                    q_r <= q_r >> 1;
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
